// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: load/store access controller between the execute/memory
// stage and the data-memory bus.
//   clk, reset           - core clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only while idle)
//   req_we/addr/fun3     - store flag, byte address, RISC-V funct3
//   req_wdata            - unshifted store value
//   resp_valid/err/rdata - one-cycle completion pulse, error flag, extended load data
//   stall                - pipeline hold until the response pulse
//   bus_*                - word-aligned bus master (cyc/stb/we/adr/sel/dat_o,
//                          dat_i/ack/err)
// Misaligned accesses crossing a word boundary are split into two bus accesses
// when SPLIT_EN != 0; each bus access is aborted after TIMEOUT wait cycles.
module lsu_access_ctrl #(
  parameter int unsigned SPLIT_EN = 1,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_fun3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP, S_ERR} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, lo_q;
  logic [2:0]  fun3_q;
  logic        we_q;
  logic [15:0] cnt_q;

  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        bus_cyc_q, bus_stb_q, bus_we_q;
  logic [31:0] bus_adr_q, bus_dat_o_q;
  logic [3:0]  bus_sel_q;

  // Lane decode works on the live request while idle (so the first bus access
  // can be launched on the accept edge) and on the captured copy afterwards.
  logic [31:0] c_addr, c_wdata, base, ld_raw, ld_ext, hi_w, lo_w;
  logic [2:0]  c_fun3;
  logic        c_we, legal, split;
  logic [1:0]  off;
  logic [3:0]  szmask;
  logic [7:0]  mask8;
  logic [63:0] wide;

  always_comb begin
    c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    c_fun3  = (state_q == S_IDLE) ? req_fun3  : fun3_q;
    c_we    = (state_q == S_IDLE) ? req_we    : we_q;
    off     = c_addr[1:0];
    base    = {c_addr[31:2], 2'b00};
    case (c_fun3[1:0])
      2'b00:   szmask = 4'b0001;
      2'b01:   szmask = 4'b0011;
      default: szmask = 4'b1111;
    endcase
    mask8 = {4'b0000, szmask} << off;
    wide  = {32'h0, c_wdata} << {off, 3'b000};
    split = |mask8[7:4];
    legal = !(c_fun3 == 3'b011 || c_fun3 == 3'b110 || c_fun3 == 3'b111)
            && !(c_we && c_fun3[2]);
    // Final ack in ACC1 supplies the high word; in ACC0 it is the only word.
    hi_w   = (state_q == S_ACC1) ? bus_dat_i : 32'h0;
    lo_w   = (state_q == S_ACC1) ? lo_q      : bus_dat_i;
    ld_raw = 32'({hi_w, lo_w} >> {off, 3'b000});
    case (c_fun3[1:0])
      2'b00:   ld_ext = c_fun3[2] ? {24'h0, ld_raw[7:0]}  : {{24{ld_raw[7]}},  ld_raw[7:0]};
      2'b01:   ld_ext = c_fun3[2] ? {16'h0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      fun3_q       <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      bus_cyc_q    <= 1'b0;
      bus_stb_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_adr_q    <= '0;
      bus_sel_q    <= '0;
      bus_dat_o_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            fun3_q      <= req_fun3;
            we_q        <= req_we;
            req_ready_q <= 1'b0;
            if (!legal || (split && SPLIT_EN == 0)) begin
              state_q      <= S_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= S_ACC0;
              cnt_q       <= '0;
              bus_cyc_q   <= 1'b1;
              bus_stb_q   <= 1'b1;
              bus_we_q    <= req_we;
              bus_adr_q   <= base;
              bus_sel_q   <= mask8[3:0];
              bus_dat_o_q <= wide[31:0];
            end
          end
        end
        S_ACC0, S_ACC1: begin
          // bus_err takes priority over a simultaneous bus_ack.
          if (bus_err || (!bus_ack && cnt_q == TO_LAST)) begin
            state_q      <= S_ERR;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            bus_cyc_q    <= 1'b0;
            bus_stb_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_dat_o_q  <= '0;
          end else if (bus_ack) begin
            if (state_q == S_ACC0 && split) begin
              state_q     <= S_ACC1;
              lo_q        <= bus_dat_i;
              cnt_q       <= '0;
              bus_adr_q   <= base + 32'd4;
              bus_sel_q   <= mask8[7:4];
              bus_dat_o_q <= wide[63:32];
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= we_q ? 32'h0 : ld_ext;
              bus_cyc_q    <= 1'b0;
              bus_stb_q    <= 1'b0;
              bus_we_q     <= 1'b0;
              bus_sel_q    <= '0;
              bus_dat_o_q  <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP, S_ERR: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign stall      = req_valid & ~resp_valid_q;
  assign bus_cyc    = bus_cyc_q;
  assign bus_stb    = bus_stb_q;
  assign bus_we     = bus_we_q;
  assign bus_adr    = bus_adr_q;
  assign bus_sel    = bus_sel_q;
  assign bus_dat_o  = bus_dat_o_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
module tb_lsu_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_a, req_valid_b, req_we;
  logic [31:0] req_addr, req_wdata, bus_dat_i;
  logic [2:0]  req_fun3;
  logic        bus_ack, bus_err;

  logic        req_ready_a, resp_valid_a, resp_err_a, stall_a;
  logic        bus_cyc_a, bus_stb_a, bus_we_a;
  logic [31:0] resp_rdata_a, bus_adr_a, bus_dat_o_a;
  logic [3:0]  bus_sel_a;

  logic        req_ready_b, resp_valid_b, resp_err_b, stall_b;
  logic        bus_cyc_b, bus_stb_b, bus_we_b;
  logic [31:0] resp_rdata_b, bus_adr_b, bus_dat_o_b;
  logic [3:0]  bus_sel_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_access_ctrl #(.SPLIT_EN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_fun3(req_fun3), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .stall(stall_a),
    .bus_cyc(bus_cyc_a), .bus_stb(bus_stb_a), .bus_we(bus_we_a),
    .bus_adr(bus_adr_a), .bus_sel(bus_sel_a), .bus_dat_o(bus_dat_o_a),
    .bus_dat_i(bus_dat_i), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  lsu_access_ctrl #(.SPLIT_EN(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_fun3(req_fun3), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .stall(stall_b),
    .bus_cyc(bus_cyc_b), .bus_stb(bus_stb_b), .bus_we(bus_we_b),
    .bus_adr(bus_adr_b), .bus_sel(bus_sel_b), .bus_dat_o(bus_dat_o_b),
    .bus_dat_i(bus_dat_i), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
    req_we = we; req_addr = addr; req_fun3 = f3; req_wdata = wd;
    req_valid_a = 1'b1;
    step();
    req_valid_a = 1'b0;
    req_addr = 32'hDEAD_BEEF; req_fun3 = 3'b111; req_wdata = 32'h5555_5555;
  endtask

  initial begin
    reset = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_we = 1'b0;
    req_addr = '0; req_fun3 = '0; req_wdata = '0;
    bus_dat_i = '0; bus_ack = 1'b0; bus_err = 1'b0;
    step(); step();
    chk("rst_ready",  32'(req_ready_a),  32'd1);
    chk("rst_rvalid", 32'(resp_valid_a), 32'd0);
    chk("rst_cyc",    32'(bus_cyc_a),    32'd0);
    chk("rst_adr",    bus_adr_a,         32'h0);
    chk("rst_sel",    32'(bus_sel_a),    32'h0);
    chk("rst_rdata",  resp_rdata_a,      32'h0);
    reset = 1'b0;
    step();

    // LB 0x1003, stall held while the request is still presented
    req_we = 1'b0; req_addr = 32'h0000_1003; req_fun3 = 3'b000; req_valid_a = 1'b1;
    step();
    chk("lb_stall", 32'(stall_a),   32'd1);
    chk("lb_ready", 32'(req_ready_a), 32'd0);
    req_valid_a = 1'b0; req_addr = 32'hDEAD_BEEF;
    chk("lb_stb",   32'(bus_stb_a), 32'd1);
    chk("lb_adr",   bus_adr_a,      32'h0000_1000);
    chk("lb_sel",   32'(bus_sel_a), 32'b1000);
    chk("lb_we",    32'(bus_we_a),  32'd0);
    bus_ack = 1'b1; bus_dat_i = 32'h80FF_1234;
    step();
    bus_ack = 1'b0;
    chk("lb_rvalid", 32'(resp_valid_a), 32'd1);
    chk("lb_err",    32'(resp_err_a),   32'd0);
    chk("lb_rdata",  resp_rdata_a,      32'hFFFF_FF80);
    chk("lb_cyc",    32'(bus_cyc_a),    32'd0);
    chk("lb_rready", 32'(req_ready_a),  32'd0);
    step();
    chk("lb_rvalid_end", 32'(resp_valid_a), 32'd0);
    chk("lb_ready_end",  32'(req_ready_a),  32'd1);

    // SW 0x2002 split across two words
    issue_a(1'b1, 32'h0000_2002, 3'b010, 32'hAABB_CCDD);
    chk("sw0_adr", bus_adr_a,      32'h0000_2000);
    chk("sw0_sel", 32'(bus_sel_a), 32'b1100);
    chk("sw0_dat", bus_dat_o_a,    32'hCCDD_0000);
    chk("sw0_we",  32'(bus_we_a),  32'd1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("sw1_stb",    32'(bus_stb_a),    32'd1);
    chk("sw1_adr",    bus_adr_a,         32'h0000_2004);
    chk("sw1_sel",    32'(bus_sel_a),    32'b0011);
    chk("sw1_dat",    bus_dat_o_a,       32'h0000_AABB);
    chk("sw1_rvalid", 32'(resp_valid_a), 32'd0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("sw_rvalid", 32'(resp_valid_a), 32'd1);
    chk("sw_err",    32'(resp_err_a),   32'd0);
    chk("sw_rdata",  resp_rdata_a,      32'h0);
    step();

    // LHU 0xFFFFFFFF wraps to word 0
    issue_a(1'b0, 32'hFFFF_FFFF, 3'b101, 32'h0);
    chk("lhu0_adr", bus_adr_a,      32'hFFFF_FFFC);
    chk("lhu0_sel", 32'(bus_sel_a), 32'b1000);
    bus_ack = 1'b1; bus_dat_i = 32'h11AB_CDEF;
    step();
    chk("lhu1_adr", bus_adr_a,      32'h0000_0000);
    chk("lhu1_sel", 32'(bus_sel_a), 32'b0001);
    bus_dat_i = 32'h0000_0022;
    step();
    bus_ack = 1'b0;
    chk("lhu_rvalid", 32'(resp_valid_a), 32'd1);
    chk("lhu_rdata",  resp_rdata_a,      32'h0000_2211);
    step();

    // LH 0x8001 stays in one word
    issue_a(1'b0, 32'h0000_8001, 3'b001, 32'h0);
    chk("lh_sel", 32'(bus_sel_a), 32'b0110);
    bus_ack = 1'b1; bus_dat_i = 32'h12F0_0D34;
    step();
    bus_ack = 1'b0;
    chk("lh_rvalid", 32'(resp_valid_a), 32'd1);
    chk("lh_rdata",  resp_rdata_a,      32'hFFFF_F00D);
    chk("lh_cyc",    32'(bus_cyc_a),    32'd0);
    step();

    // SPLIT_EN=0 instance: misaligned LW, then illegal funct3
    req_we = 1'b0; req_addr = 32'h0000_3001; req_fun3 = 3'b010; req_valid_b = 1'b1;
    step();
    req_valid_b = 1'b0;
    chk("ns_mis_stb",    32'(bus_stb_b),    32'd0);
    chk("ns_mis_rvalid", 32'(resp_valid_b), 32'd1);
    chk("ns_mis_err",    32'(resp_err_b),   32'd1);
    chk("ns_mis_rdata",  resp_rdata_b,      32'h0);
    step();
    chk("ns_mis_end", 32'(resp_valid_b), 32'd0);
    req_addr = 32'h0000_3000; req_fun3 = 3'b011; req_valid_b = 1'b1;
    step();
    req_valid_b = 1'b0;
    chk("ns_ill_stb",    32'(bus_stb_b),    32'd0);
    chk("ns_ill_rvalid", 32'(resp_valid_b), 32'd1);
    chk("ns_ill_err",    32'(resp_err_b),   32'd1);
    step();

    // Illegal store with unsigned funct3
    issue_a(1'b1, 32'h0000_3000, 3'b100, 32'h1);
    chk("ill_st_stb", 32'(bus_stb_a),  32'd0);
    chk("ill_st_err", 32'(resp_err_a), 32'd1);
    step();

    // Timeout after 4 wait cycles
    issue_a(1'b0, 32'h0000_4000, 3'b010, 32'h0);
    step(); step(); step();
    chk("to_cyc_hold", 32'(bus_cyc_a),    32'd1);
    chk("to_no_resp",  32'(resp_valid_a), 32'd0);
    step();
    chk("to_cyc_drop", 32'(bus_cyc_a),    32'd0);
    chk("to_rvalid",   32'(resp_valid_a), 32'd1);
    chk("to_err",      32'(resp_err_a),   32'd1);
    step();

    // Split load, access 1 sees err together with ack
    issue_a(1'b0, 32'h0000_5002, 3'b010, 32'h0);
    bus_ack = 1'b1; bus_dat_i = 32'h1234_5678;
    step();
    bus_err = 1'b1;
    step();
    bus_ack = 1'b0; bus_err = 1'b0;
    chk("se_rvalid", 32'(resp_valid_a), 32'd1);
    chk("se_err",    32'(resp_err_a),   32'd1);
    chk("se_rdata",  resp_rdata_a,      32'h0);
    chk("se_cyc",    32'(bus_cyc_a),    32'd0);
    step();

    // Reset during ACC1 wait, late ack ignored, then normal LW
    issue_a(1'b0, 32'h0000_6001, 3'b010, 32'h0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    chk("mr_in_acc1", 32'(bus_cyc_a), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_cyc",    32'(bus_cyc_a),    32'd0);
    chk("mr_ready",  32'(req_ready_a),  32'd1);
    chk("mr_rvalid", 32'(resp_valid_a), 32'd0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("late_ack_rvalid", 32'(resp_valid_a), 32'd0);
    chk("late_ack_cyc",    32'(bus_cyc_a),    32'd0);
    issue_a(1'b0, 32'h0000_7000, 3'b010, 32'h0);
    chk("lw_adr", bus_adr_a,      32'h0000_7000);
    chk("lw_sel", 32'(bus_sel_a), 32'b1111);
    bus_ack = 1'b1; bus_dat_i = 32'hCAFE_F00D;
    step();
    bus_ack = 1'b0;
    chk("lw_rvalid", 32'(resp_valid_a), 32'd1);
    chk("lw_err",    32'(resp_err_a),   32'd0);
    chk("lw_rdata",  resp_rdata_a,      32'hCAFE_F00D);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
Name: lsu_access_ctrl

Overview:
- Load/store access controller between the execute/memory pipeline stage and the data-memory bus.
- Accepts one load/store request at a time and checks alignment and funct3 legality.
- Splits a misaligned access into two word-aligned bus transactions, generates byte enables and lane-shifted store data, and merges and sign/zero-extends load data.
- Holds the pipeline stalled until it responds.

Parameters:
- SPLIT_EN, 1: 1 = misaligned accesses are split into two bus accesses; 0 = a misaligned access returns resp_err with no bus activity.
- TIMEOUT, 1023: maximum cycles to wait for bus_ack/bus_err per bus access before forcing an error. Range 1..65535.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_fun3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  32  unshifted rs2 store value
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned (SPLIT_EN=0), illegal funct3, bus error, or timeout
- stall  out  1  pipeline hold; equals req_valid & ~resp_valid while busy
- bus_cyc  out  1  bus cycle active
- bus_stb  out  1  bus strobe
- bus_we  out  1  bus write
- bus_adr  out  32  word address, bits [1:0] = 0
- bus_sel  out  4  byte lane enables
- bus_dat_o  out  32  lane-aligned write data
- bus_dat_i  in  32  read data
- bus_ack  in  1  access done
- bus_err  in  1  access failed

Behaviour:
- Reset values (all registered outputs): FSM = IDLE; req_ready = 1; resp_valid = 0; resp_err = 0; resp_rdata = 0; bus_cyc = 0; bus_stb = 0; bus_we = 0; bus_adr = 0; bus_sel = 0; bus_dat_o = 0; timeout counter = 0.
- Accept rule: a request is accepted on a clk edge where req_valid & req_ready. Address, fun3, we and data are captured at that edge; later changes on req_* are ignored.
- Size: sz = 1/2/4 bytes from fun3[1:0]. off = addr[1:0].
- Legality: fun3 values 011, 110, 111 are illegal; a store with fun3[2] = 1 is illegal.
- Misaligned: H with off = 3, or W with off != 0. (H at off = 1 stays within one word and is not split.)
- Lane map: mask = (sz-bit ones) << off, giving an 8-bit mask; wide data = {32'b0, wdata} << 8*off, 64-bit. Lower halves go to access 0 at {addr[31:2], 2'b00}; upper halves go to access 1 at that address + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000). A split is needed iff mask[7:4] != 0.
- FSM states and transitions:
  - IDLE -> ERR if illegal, or misaligned with SPLIT_EN = 0.
  - IDLE -> ACC0 otherwise.
  - ACC0: cyc = stb = 1 with access-0 fields. On ack: capture bus_dat_i into lo; go to ACC1 if split, else RESP. On err or timeout: go to ERR.
  - ACC1: cyc = stb = 1 with access-1 fields. On ack: capture into hi, go to RESP. On err or timeout: go to ERR.
  - RESP: resp_valid = 1, resp_err = 0, then IDLE.
  - ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0, then IDLE.
- bus_cyc and bus_stb drop to 0 on the cycle after the final ack/err. No bus strobe is ever issued for an ERR-from-IDLE request.
- Load merge: ({hi, lo} >> 8*off) truncated to sz bytes; sign-extended when fun3[2] = 0, zero-extended otherwise.
- Latency: aligned access with zero-wait ack = request accepted at edge T, bus strobe during T+1, resp_valid during T+2. A split access adds 1 cycle plus bus waits. Illegal request: resp_valid during T+1.
- Simultaneous bus_ack and bus_err: err wins.
- Timeout: the counter clears on entry to each ACC state and increments every cycle without ack/err. When count reaches TIMEOUT, the FSM goes to ERR and bus_cyc drops.
- Split-store failure: if access 1 errors after access 0 was acked, the first-word write is not undone (non-atomic). resp_err = 1.
- Reset mid-operation: the next edge forces the IDLE reset values, and bus_cyc drops. A late bus_ack arriving in IDLE is ignored.
- No new request is accepted in the RESP/ERR cycle (req_ready = 0). It is accepted on the following cycle.

Test Plan:
- LB, addr 0x1003, memory word at 0x1000 = 0x80FF_1234, ack after 0 waits -> one access, bus_sel = 1000, resp_rdata = 0xFFFF_FF80 at T+2, resp_err = 0.
- SW, addr 0x2002, wdata 0xAABB_CCDD, SPLIT_EN = 1 -> access at 0x2000 with sel 1100 and dat_o 0xCCDD_0000, then access at 0x2004 with sel 0011 and dat_o 0x0000_AABB; resp_valid with err = 0.
- LHU, addr 0xFFFF_FFFF, words 0x11xx_xxxx at 0xFFFF_FFFC and 0x0000_0022 at 0x0000_0000 -> second bus_adr = 0x0000_0000 (wrap), resp_rdata = 0x0000_2211.
- SPLIT_EN = 0, LW at 0x3001; then fun3 = 011 -> each gives no bus_stb and resp_valid with err = 1 at T+1.
- LW, bus never acks, TIMEOUT = 4 -> bus_cyc drops after 4 wait cycles, resp_err = 1. Split load with bus_err asserted on access 1 -> resp_err = 1, rdata = 0.
- Reset asserted during ACC1 wait -> next cycle bus_cyc = 0, req_ready = 1, resp_valid = 0. A following aligned LW completes normally.
